// File: rtl/mem_dual_clr.sv
// Simple dual-port RAM with a hardware zero-fill sequencer.
// The fill runs after reset and on a clear pulse; user access is locked out meanwhile.
module mem_dual_clr #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 64,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     clear,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   cnt_q;
  logic [AW-1:0]   cnt_d;

  logic            wr_ok;
  logic            rd_in;
  logic            rd_acc;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [AW-1:0]   raddr;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q;

  logic             v1;
  logic             zero1;
  logic             byp1;
  logic [WIDTH-1:0] bypd1;
  logic [WIDTH-1:0] s1_data;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q == CLEAR);
    wr_ok     = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);
    rd_in     = ({1'b0, rd_addr} < DEPTH_W);
    rd_acc    = rd_en && !busy;
    raddr     = rd_in ? rd_addr : '0;
    mem_we    = wr_ok;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end
  end

  // No reset on the array or its read register so they map onto block RAM.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (rd_acc) ram_q <= mem[raddr];
  end

  // zero1 comes out of reset set, so rd_data reads zero until the first read.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      zero1 <= 1'b1;
      byp1  <= 1'b0;
      bypd1 <= '0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) begin
        zero1 <= !rd_in;
        byp1  <= (RDW_MODE != 0) && wr_ok
                 && (wr_addr == rd_addr);
        bypd1 <= wr_data;
      end
    end
  end

  assign s1_data = zero1 ? '0
                 : byp1  ? bypd1
                 : ram_q;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] rd_q;
      logic             v2;
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= '0;
          v2   <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) rd_q <= s1_data;
        end
      end
      assign rd_data  = rd_q;
      assign rd_valid = v2;
    end else begin : g_noreg
      assign rd_data  = s1_data;
      assign rd_valid = v1;
    end
  endgenerate

endmodule

// File: tb/tb_mem_dual_clr.sv
// Directed bench for mem_dual_clr: three configurations share clock and reset.
// a: defaults, b: RDW new-data with output register, c: DEPTH=48.
module tb_mem_dual_clr;

  logic       clock = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [5:0] rd_addr = '0;

  logic       a_busy, a_valid;
  logic [7:0] a_data;
  logic       b_busy, b_valid;
  logic [7:0] b_data;

  logic       c_clear = 1'b0;
  logic       c_wr_en = 1'b0;
  logic [5:0] c_wr_addr = '0;
  logic [7:0] c_wr_data = '0;
  logic       c_rd_en = 1'b0;
  logic [5:0] c_rd_addr = '0;
  logic       c_busy, c_valid;
  logic [7:0] c_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_dual_clr #(.WIDTH(8), .DEPTH(64), .RDW_MODE(0),
    .OUT_REG(0), .CLEAR_ON_RESET(1)) dut_a (
    .clock(clock), .rst_n(rst_n), .clear(clear), .busy(a_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(a_data), .rd_valid(a_valid));

  mem_dual_clr #(.WIDTH(8), .DEPTH(64), .RDW_MODE(1),
    .OUT_REG(1), .CLEAR_ON_RESET(1)) dut_b (
    .clock(clock), .rst_n(rst_n), .clear(clear), .busy(b_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(b_data), .rd_valid(b_valid));

  mem_dual_clr #(.WIDTH(8), .DEPTH(48), .RDW_MODE(0),
    .OUT_REG(0), .CLEAR_ON_RESET(1)) dut_c (
    .clock(clock), .rst_n(rst_n), .clear(c_clear), .busy(c_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr),
    .rd_data(c_data), .rd_valid(c_valid));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    tick();
    checks++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1 || c_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got a=%b b=%b c=%b expected 1 1 1",
               a_busy, b_busy, c_busy);
    end
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0 || c_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got a=%b b=%b c=%b expected 0 0 0",
               a_valid, b_valid, c_valid);
    end
    checks++;
    if (a_data !== 8'h00 || b_data !== 8'h00 || c_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got a=%h b=%h c=%h expected 00",
               a_data, b_data, c_data);
    end
  endtask

  task automatic count_fill(input string tag);
    int n, na, nc;
    n = 0; na = 0; nc = 0;
    while ((a_busy || c_busy) && n < 200) begin
      tick();
      n++;
      if (!a_busy && na == 0) na = n;
      if (!c_busy && nc == 0) nc = n;
    end
    checks++;
    if (na != 64) begin
      errors++;
      $display("FAIL %s_len64: got %0d cycles expected 64", tag, na);
    end
    checks++;
    if (nc != 48) begin
      errors++;
      $display("FAIL %s_len48: got %0d cycles expected 48", tag, nc);
    end
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_b_idle: got %b expected 0", tag, b_busy);
    end
  endtask

  task automatic test_fill;
    rst_n = 1'b1;
    count_fill("fill");
    for (int i = 0; i < 64; i++) begin
      rd_en = 1'b1;
      rd_addr = 6'(i);
      tick();
      checks++;
      if (a_valid !== 1'b1 || a_data !== 8'h00) begin
        errors++;
        $display("FAIL fill_rd_a[%0d]: got v=%b d=%h expected 1 00",
                 i, a_valid, a_data);
      end
      if (i > 0) begin
        checks++;
        if (b_valid !== 1'b1 || b_data !== 8'h00) begin
          errors++;
          $display("FAIL fill_rd_b[%0d]: got v=%b d=%h expected 1 00",
                   i, b_valid, b_data);
        end
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b1) begin
      errors++;
      $display("FAIL fill_tail: got a_v=%b b_v=%b expected 0 1",
               a_valid, b_valid);
    end
    tick();
  endtask

  task automatic test_basic;
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 6'd5;
    tick();
    rd_en = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_a: got v=%b d=%h expected 1 a5", a_valid, a_data);
    end
    checks++;
    if (b_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_b_early: got v=%b expected 0", b_valid);
    end
    tick();
    checks++;
    if (a_valid !== 1'b0 || a_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_a_hold: got v=%b d=%h expected 0 a5",
               a_valid, a_data);
    end
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_b: got v=%b d=%h expected 1 a5", b_valid, b_data);
    end
    tick();
    checks++;
    if (b_valid !== 1'b0 || b_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_b_hold: got v=%b d=%h expected 0 a5",
               b_valid, b_data);
    end
  endtask

  task automatic test_rdw;
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 8'h11;
    tick();
    wr_data = 8'h22;
    rd_en = 1'b1; rd_addr = 6'd9;
    tick();
    wr_en = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h11) begin
      errors++;
      $display("FAIL rdw_old: got v=%b d=%h expected 1 11", a_valid, a_data);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h22) begin
      errors++;
      $display("FAIL rdw_a_next: got v=%b d=%h expected 1 22",
               a_valid, a_data);
    end
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'h22) begin
      errors++;
      $display("FAIL rdw_new: got v=%b d=%h expected 1 22", b_valid, b_data);
    end
    tick();
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'h22) begin
      errors++;
      $display("FAIL rdw_b_next: got v=%b d=%h expected 1 22",
               b_valid, b_data);
    end
    tick();
  endtask

  task automatic test_clear;
    int n, k;
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'h5C;
    tick();
    wr_addr = 6'd63; wr_data = 8'h66;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 6'd3;
    tick();
    rd_en = 1'b0;
    checks++;
    if (a_data !== 8'h5C) begin
      errors++;
      $display("FAIL clear_pre: got %h expected 5c", a_data);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_start: got a=%b b=%b expected 1 1", a_busy, b_busy);
    end
    n = 1; k = 0;
    while (a_busy && k < 200) begin
      wr_en = (k < 5); wr_addr = 6'd3; wr_data = 8'hFF;
      rd_en = (k < 5); rd_addr = 6'd3;
      clear = (k == 30);
      tick();
      if (k <= 6) begin
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
          errors++;
          $display("FAIL clear_no_rd[%0d]: got a=%b b=%b expected 0 0",
                   k, a_valid, b_valid);
        end
      end
      if (a_busy) n++;
      k++;
    end
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL clear_len: got %0d cycles expected 64", n);
    end
    rd_en = 1'b1; rd_addr = 6'd3;
    tick();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h00) begin
      errors++;
      $display("FAIL clear_addr3: got v=%b d=%h expected 1 00",
               a_valid, a_data);
    end
    rd_addr = 6'd63;
    tick();
    rd_en = 1'b0;
    checks++;
    if (a_data !== 8'h00 || b_data !== 8'h00) begin
      errors++;
      $display("FAIL clear_addr63: got a=%h b=%h expected 00", a_data, b_data);
    end
    tick();
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'h00) begin
      errors++;
      $display("FAIL clear_b63: got v=%b d=%h expected 1 00", b_valid, b_data);
    end
  endtask

  task automatic test_reset_mid;
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 6'd7;
    clear = 1'b1;
    tick();
    rd_en = 1'b0; clear = 1'b0;
    for (int i = 1; i < 30; i++) tick();
    checks++;
    if (a_busy !== 1'b1 || a_data !== 8'h3C || b_data !== 8'h3C) begin
      errors++;
      $display("FAIL mid_pre: got busy=%b a=%h b=%h expected 1 3c 3c",
               a_busy, a_data, b_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_valid !== 1'b0 || a_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst_a: got v=%b d=%h expected 0 00", a_valid, a_data);
    end
    checks++;
    if (b_valid !== 1'b0 || b_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst_b: got v=%b d=%h expected 0 00", b_valid, b_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    count_fill("mid");
  endtask

  task automatic test_oob;
    c_wr_en = 1'b1; c_wr_addr = 6'd2; c_wr_data = 8'h12;
    tick();
    c_wr_addr = 6'd18; c_wr_data = 8'h34;
    tick();
    c_wr_addr = 6'd47; c_wr_data = 8'h9A;
    tick();
    c_wr_addr = 6'd50; c_wr_data = 8'h77;
    tick();
    c_wr_en = 1'b0;
    c_rd_en = 1'b1; c_rd_addr = 6'd2;
    tick();
    checks++;
    if (c_valid !== 1'b1 || c_data !== 8'h12) begin
      errors++;
      $display("FAIL oob_addr2: got v=%b d=%h expected 1 12", c_valid, c_data);
    end
    c_rd_addr = 6'd18;
    tick();
    checks++;
    if (c_valid !== 1'b1 || c_data !== 8'h34) begin
      errors++;
      $display("FAIL oob_addr18: got v=%b d=%h expected 1 34", c_valid, c_data);
    end
    c_rd_addr = 6'd47;
    tick();
    checks++;
    if (c_valid !== 1'b1 || c_data !== 8'h9A) begin
      errors++;
      $display("FAIL oob_addr47: got v=%b d=%h expected 1 9a", c_valid, c_data);
    end
    c_rd_addr = 6'd50;
    tick();
    c_rd_en = 1'b0;
    checks++;
    if (c_valid !== 1'b1 || c_data !== 8'h00) begin
      errors++;
      $display("FAIL oob_addr50: got v=%b d=%h expected 1 00", c_valid, c_data);
    end
    tick();
    checks++;
    if (c_valid !== 1'b0 || c_data !== 8'h00) begin
      errors++;
      $display("FAIL oob_hold: got v=%b d=%h expected 0 00", c_valid, c_data);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_rdw();
    test_clear();
    test_reset_mid();
    test_oob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dual_clr.md
MEM_DUAL_CLR -- requirements
Module: mem_dual_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: number of words, any value >= 2, power of two not required.
REQ-003 SHALL have parameter RDW_MODE, default 0: same-address read-during-write result; 0 = old data, 1 = new data.
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds one output pipeline register.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 zero-fills the array automatically after reset.
REQ-006 SHALL have port clock, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port clear, input, 1 bit: single-cycle pulse that requests a zero-fill of the whole array.
REQ-009 SHALL have port busy, output, 1 bit: high while a zero-fill is in progress.
REQ-010 SHALL have port wr_en, input, 1 bit: write strobe.
REQ-011 SHALL have port wr_addr, input, CLOG2(DEPTH) bits: write address.
REQ-012 SHALL have port wr_data, input, WIDTH bits: write data.
REQ-013 SHALL have port rd_en, input, 1 bit: read strobe.
REQ-014 SHALL have port rd_addr, input, CLOG2(DEPTH) bits: read address.
REQ-015 SHALL have port rd_data, output, WIDTH bits: read data.
REQ-016 SHALL have port rd_valid, output, 1 bit: rd_data carries the result of an accepted read.

Function
REQ-017 SHALL implement simple dual-port storage of DEPTH x WIDTH, with independent write and read ports usable in the same cycle.
REQ-018 SHALL infer block RAM for the storage array; the array itself SHALL have no reset.
REQ-019 SHALL use a two-state controller, IDLE and CLEAR; busy SHALL be a registered output equal to (state == CLEAR).
REQ-020 SHALL, in IDLE with clear=1, go to CLEAR on the next edge with the clear counter at 0.
REQ-021 SHALL, in CLEAR, write zero to address cnt on each cycle and increment cnt; when cnt = DEPTH-1 is written, it SHALL return to IDLE and reset cnt to 0.
REQ-022 SHALL therefore hold busy high for exactly DEPTH cycles per zero-fill.
REQ-023 SHALL ignore clear while busy=1; an in-progress zero-fill is not restarted.
REQ-024 SHALL, while busy=1, ignore external wr_en and rd_en: no array write, no read accepted, and rd_valid deasserted for reads issued in those cycles.
REQ-025 SHALL accept a read when rd_en=1 and busy=0; data SHALL appear with latency 1+OUT_REG cycles, with rd_valid high in that same cycle.
REQ-026 SHALL, when OUT_REG=1, let read requests pipeline back-to-back at one per cycle with no bubbles.
REQ-027 SHALL hold rd_data at its last value when no read completes; rd_valid is high only in the completing cycle.
REQ-028 SHALL resolve a same-cycle write and read of the same address per RDW_MODE: 0 returns the pre-write word, 1 returns wr_data.
REQ-029 SHALL drop writes with wr_addr >= DEPTH; reads with rd_addr >= DEPTH SHALL complete normally with rd_data all-zero.

Reset
REQ-030 SHALL, while rst_n=0, force rd_data=0, rd_valid=0, clear counter=0 and all pipeline valid bits to 0.
REQ-031 SHALL, while rst_n=0, set state=CLEAR if CLEAR_ON_RESET=1, else state=IDLE, with busy following state.
REQ-032 SHALL, on reset asserted mid-fill, abort the fill; with CLEAR_ON_RESET=1 the fill restarts from address 0 after release.
REQ-033 SHALL discard reads in flight at reset assertion; they produce no rd_valid.

Verification
REQ-034 SHALL be verified for post-reset fill (WIDTH=8, DEPTH=64, CLEAR_ON_RESET=1): release rst_n -> busy=1 for 64 cycles then 0; reads of addresses 0..63 all return 8'h00.
REQ-035 SHALL be verified for basic write/read (OUT_REG=0): write 8'hA5 to address 5, read address 5 the next cycle -> rd_data=8'hA5 with rd_valid=1 one cycle later; with OUT_REG=1 -> two cycles later.
REQ-036 SHALL be verified for read-during-write: address 9 holds 8'h11; in one cycle write 8'h22 to 9 and read 9 -> rd_data=8'h11 (RDW_MODE=0) or 8'h22 (RDW_MODE=1); a following read returns 8'h22.
REQ-037 SHALL be verified for clear while active: pulse clear, issue wr_en to address 3 with 8'hFF and rd_en during busy -> write ignored, no rd_valid; after busy falls, address 3 reads 8'h00; a second clear pulse issued mid-fill leaves the busy length at 64.
REQ-038 SHALL be verified for reset mid-fill: assert rst_n=0 at fill cycle 30 -> rd_valid=0 and rd_data=0 immediately; after release, busy=1 for a full 64 cycles.
REQ-039 SHALL be verified for out-of-range access (DEPTH=48): write 8'h77 to address 50 -> no array location changes; read address 50 -> rd_data=8'h00 with rd_valid=1.
